switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 95 +++++++++
 tb/tb_switch_debouncer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// switch_debouncer : two-flop synchronizer, per-bit debounce, change strobe.
// Optional SWITCH_DEBOUNCER_EDGE_DETECT_EN adds per-bit rise/fall pulses.
// Revision 1.0
// ============================================================================
module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_switches,
  output logic [WIDTH-1:0] switches,
`ifdef SWITCH_DEBOUNCER_EDGE_DETECT_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic             changed
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     r_sync1;
  logic [WIDTH-1:0]     r_sync2;
  logic [WIDTH-1:0]     r_switches;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_cnt     [WIDTH];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0]     w_sw_nxt;
  logic [WIDTH-1:0]     w_update;

  // Any agreement between s2 and the output restarts that bit's count.
  always_comb begin
    w_sw_nxt = r_switches;
    w_update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_switches[i]) begin
        if (r_cnt[i] == c_CNT_MAX) begin
          w_sw_nxt[i] = r_sync2[i];
          w_update[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + c_CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_switches <= '0;
      r_changed  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= raw_switches;
      r_sync2    <= r_sync1;
      r_switches <= w_sw_nxt;
      r_changed  <= |w_update;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign switches = r_switches;
  assign changed  = r_changed;

`ifdef SWITCH_DEBOUNCER_EDGE_DETECT_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_update & w_sw_nxt;
      r_fall <= w_update & ~w_sw_nxt;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for switch_debouncer: directed scenarios plus random hold lengths,
// every cycle compared against a window-based reference model.
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int S = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_switches = '0;
  logic [W-1:0] switches;
  logic         changed;
`ifdef SWITCH_DEBOUNCER_EDGE_DETECT_EN
  logic [W-1:0] rise;
  logic [W-1:0] fall;
`endif

  switch_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (S)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .raw_switches (raw_switches),
    .switches     (switches),
`ifdef SWITCH_DEBOUNCER_EDGE_DETECT_EN
    .rise         (rise),
    .fall         (fall),
`endif
    .changed      (changed)
  );

  always #5 clock = ~clock;

  int n_vec   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  // Model: raw samples per edge; a bit flips once the last S synchronized
  // samples (raw delayed two edges) all disagree with the current output.
  logic [W-1:0] q_raw [$];
  logic [W-1:0] q_s2  [$];
  logic [W-1:0] m_out;
  logic         m_chg;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_raw.delete();
    q_s2.delete();
    m_out  = '0;
    m_chg  = 1'b0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw);
    logic [W-1:0] s2;
    logic [W-1:0] nxt;
    bit           all_diff;
    s2 = (q_raw.size() >= 2) ? q_raw[q_raw.size()-2] : '0;
    q_raw.push_back(raw);
    if (q_raw.size() > 4) void'(q_raw.pop_front());
    q_s2.push_back(s2);
    if (q_s2.size() > S) void'(q_s2.pop_front());
    nxt = m_out;
    for (int i = 0; i < W; i++) begin
      if (q_s2.size() == S) begin
        all_diff = 1'b1;
        foreach (q_s2[j]) if (q_s2[j][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_out[i];
      end
    end
    m_rise = nxt & ~m_out;
    m_fall = ~nxt & m_out;
    m_chg  = |(nxt ^ m_out);
    m_out  = nxt;
  endtask

  task automatic step(input logic [W-1:0] raw);
    raw_switches = raw;
    @(posedge clock);
    model_edge(raw);
    #1;
    chk("switches", switches, m_out);
    chk("changed", changed, m_chg);
`ifdef SWITCH_DEBOUNCER_EDGE_DETECT_EN
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
`endif
    if (changed) n_pulse++;
  endtask

  task automatic apply_reset(input int cycles);
    #2 reset = 1'b0;
    #1;
    chk("rst_switches", switches, '0);
    chk("rst_changed", changed, 1'b0);
    model_clear();
    repeat (cycles) begin
      @(posedge clock);
      #1;
      chk("rst_hold", {changed, switches}, '0);
    end
    reset = 1'b1;
  endtask

  // Edges from first sampling of raw until changed is seen (bounded).
  task automatic latency(input logic [W-1:0] raw, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int j = 1; j <= 30; j++) begin
      step(raw);
      if (changed && lat < 0) lat = j - 1;
    end
    chk(tag, lat, exp_lat);
  endtask

  initial begin
    int p0, p1, p2;
    logic [W-1:0] val;
    int hold;

    model_clear();
    reset = 1'b0;
    raw_switches = 4'b1111;
    #6;
    chk("init_switches", switches, '0);
    chk("init_changed", changed, 1'b0);
    #1 reset = 1'b1;

    p0 = n_pulse;
    latency(4'b1111, S + 1, "lat_after_init");
    chk("init_pulses", n_pulse - p0, 1);
    chk("init_final", switches, 4'b1111);

    raw_switches = 4'b0000;
    apply_reset(3);
    repeat (5) step(4'b0000);

    latency(4'b0101, S + 1, "lat_clean");
    chk("clean_final", switches, 4'b0101);
    repeat (20) step(4'b0000);

    p0 = n_pulse;
    for (int c = 0; c < 100; c++) step(((c / 5) % 2 == 0) ? 4'b0001 : 4'b0000);
    chk("bounce_pulses", n_pulse - p0, 0);
    latency(4'b0001, S + 1, "lat_bounce");
    chk("bounce_final", switches, 4'b0001);

    p0 = n_pulse;
    repeat (S - 1) step(4'b0101);
    repeat (20) step(4'b0001);
    chk("thresh_short", n_pulse - p0, 0);
    p0 = n_pulse;
    repeat (S) step(4'b0101);
    repeat (20) step(4'b0001);
    chk("thresh_exact", n_pulse - p0, 2);

    p1 = -1;
    p2 = -1;
    for (int j = 0; j < 30; j++) begin
      step((j < 3) ? 4'b0011 : 4'b1011);
      if (changed) begin
        if (p1 < 0) p1 = j;
        else if (p2 < 0) p2 = j;
      end
    end
    chk("indep_first", p1, S + 1);
    chk("indep_second", p2, S + 4);
    p0 = n_pulse;
    repeat (30) step(4'b0001);
    chk("same_edge_pulses", n_pulse - p0, 1);

    repeat (20) step(4'b0000);
    repeat (8) step(4'b0001);
    apply_reset(4);
    latency(4'b0001, S + 1, "lat_after_midreset");
    repeat (30) step(4'b0000);

    for (int seg = 0; seg < 150; seg++) begin
      val  = W'($urandom);
      hold = $urandom_range(1, 24);
      repeat (hold) step(val);
      if ($urandom_range(0, 39) == 0) apply_reset($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
